// File: rtl/hdmi_i2c_responder.sv
// I2C target for the HDMI DDC/config bus: one register pointer, write strobes, and
// sequential reads with auto-increment. SDA is open-drain (drives 0 or releases).
module hdmi_i2c_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h39,
  parameter int         FILT_LEN = 3
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic [7:0] oSUBADDR,
  input  logic [7:0] iRD_DATA,
  output logic       oWR_STB,
  output logic [7:0] oWR_ADDR,
  output logic [7:0] oWR_DATA,
  output logic       oBUSY
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_DEVADDR, ST_ACK_DEV, ST_SUBADDR, ST_ACK_SUB,
    ST_WDATA, ST_ACK_WR, ST_RDATA, ST_RACK
  } state_t;

  logic          r_scl_meta, r_scl_sync, r_scl_filt, r_scl_d;
  logic          r_sda_meta, r_sda_sync, r_sda_filt, r_sda_d;
  logic [CW-1:0] r_scl_cnt, r_sda_cnt;
  state_t        r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [1:0]    r_phase;
  logic          r_rw;
  logic          r_sda_oe;
  logic [7:0]    r_subaddr;
  logic          r_wr_stb;
  logic [7:0]    r_wr_addr;
  logic [7:0]    r_wr_data;
  logic          r_busy;

  logic          w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]    w_byte;

  assign I2C_SDAT = r_sda_oe ? 1'b0 : 1'bz;
  assign oSUBADDR = r_subaddr;
  assign oWR_STB  = r_wr_stb;
  assign oWR_ADDR = r_wr_addr;
  assign oWR_DATA = r_wr_data;
  assign oBUSY    = r_busy;

  assign w_scl_rise = r_scl_filt & ~r_scl_d;
  assign w_scl_fall = ~r_scl_filt & r_scl_d;
  assign w_start    = r_scl_filt & r_scl_d & r_sda_d & ~r_sda_filt;
  assign w_stop     = r_scl_filt & r_scl_d & ~r_sda_d & r_sda_filt;
  assign w_byte     = {r_shift[6:0], r_sda_filt};

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_meta <= I2C_SCLK;
      r_scl_sync <= r_scl_meta;
      r_sda_meta <= I2C_SDAT;
      r_sda_sync <= r_sda_meta;
      r_scl_d    <= r_scl_filt;
      r_sda_d    <= r_sda_filt;
    end
  end

  // A new level is accepted only after FILT_LEN consecutive differing samples.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_scl_cnt  <= '0;
      r_scl_filt <= 1'b1;
    end else if (r_scl_sync == r_scl_filt) begin
      r_scl_cnt  <= '0;
    end else if (r_scl_cnt == CW'(FILT_LEN - 1)) begin
      r_scl_cnt  <= '0;
      r_scl_filt <= r_scl_sync;
    end else begin
      r_scl_cnt  <= r_scl_cnt + CW'(1);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sda_cnt  <= '0;
      r_sda_filt <= 1'b1;
    end else if (r_sda_sync == r_sda_filt) begin
      r_sda_cnt  <= '0;
    end else if (r_sda_cnt == CW'(FILT_LEN - 1)) begin
      r_sda_cnt  <= '0;
      r_sda_filt <= r_sda_sync;
    end else begin
      r_sda_cnt  <= r_sda_cnt + CW'(1);
    end
  end

  // r_phase tracks progress through the 9th-bit window (ACK drive / read ACK sample).
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_phase   <= 2'd0;
      r_rw      <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_subaddr <= 8'h00;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= 8'h00;
      r_wr_data <= 8'h00;
      r_busy    <= 1'b0;
    end else begin
      r_wr_stb <= 1'b0;
      if (w_stop) begin
        r_state  <= ST_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        r_state   <= ST_DEVADDR;
        r_bit_cnt <= 3'd0;
        r_phase   <= 2'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b1;
      end else begin
        case (r_state)
          ST_DEVADDR: if (w_scl_rise) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_phase   <= 2'd0;
            if (r_bit_cnt == 3'd7) begin
              r_rw    <= r_sda_filt;
              r_state <= (w_byte[7:1] == DEV_ADDR) ? ST_ACK_DEV : ST_IDLE;
            end
          end
          ST_SUBADDR: if (w_scl_rise) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_phase   <= 2'd0;
            if (r_bit_cnt == 3'd7) begin
              r_subaddr <= w_byte;
              r_state   <= ST_ACK_SUB;
            end
          end
          ST_WDATA: if (w_scl_rise) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_phase   <= 2'd0;
            if (r_bit_cnt == 3'd7) begin
              r_wr_stb  <= 1'b1;
              r_wr_addr <= r_subaddr;
              r_wr_data <= w_byte;
              r_state   <= ST_ACK_WR;
            end
          end
          ST_ACK_DEV, ST_ACK_SUB, ST_ACK_WR: if (w_scl_fall) begin
            if (r_phase == 2'd0) begin
              r_sda_oe <= 1'b1;
              r_phase  <= 2'd1;
            end else begin
              r_sda_oe  <= 1'b0;
              r_phase   <= 2'd0;
              r_bit_cnt <= 3'd0;
              if (r_state == ST_ACK_DEV) begin
                if (r_rw) begin
                  r_shift  <= iRD_DATA;
                  r_sda_oe <= ~iRD_DATA[7];
                  r_state  <= ST_RDATA;
                end else begin
                  r_state <= ST_SUBADDR;
                end
              end else begin
                if (r_state == ST_ACK_WR) r_subaddr <= r_subaddr + 8'd1;
                r_state <= ST_WDATA;
              end
            end
          end
          ST_RDATA: if (w_scl_rise) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_phase <= 2'd0;
              r_state <= ST_RACK;
            end
          end else if (w_scl_fall) begin
            r_shift  <= {r_shift[6:0], 1'b0};
            r_sda_oe <= ~r_shift[6];
          end
          ST_RACK: begin
            if (w_scl_fall && r_phase == 2'd0) begin
              r_sda_oe <= 1'b0;
              r_phase  <= 2'd1;
            end else if (w_scl_rise && r_phase == 2'd1) begin
              if (r_sda_filt) begin
                r_state <= ST_IDLE;
              end else begin
                r_subaddr <= r_subaddr + 8'd1;
                r_phase   <= 2'd2;
              end
            end else if (w_scl_fall && r_phase == 2'd2) begin
              r_shift   <= iRD_DATA;
              r_sda_oe  <= ~iRD_DATA[7];
              r_bit_cnt <= 3'd0;
              r_phase   <= 2'd0;
              r_state   <= ST_RDATA;
            end
          end
          default: begin
            r_sda_oe <= 1'b0;
            r_state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hdmi_i2c_responder.sv
// Self-checking bench: bit-banged I2C controller, write-strobe scoreboard,
// read-byte scoreboard, and open-drain activity monitor.
module tb_hdmi_i2c_responder;

  localparam int Q = 25;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       tb_sda_low;
  wire        sda_bus;
  logic [7:0] subaddr, rd_data, wr_addr, wr_data;
  logic       wr_stb, busy;

  int          n_checks = 0;
  int          n_pass = 0;
  int          resp_low_cnt = 0;
  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [15:0] mon_e;

  always #10 clk = ~clk;

  pullup (sda_bus);
  assign sda_bus = tb_sda_low ? 1'b0 : 1'bz;

  // User-side register file: only 0x41/0x42 hold the values the read test expects.
  assign rd_data = (subaddr == 8'h41) ? 8'h10 : (subaddr == 8'h42) ? 8'h20 : ~subaddr;

  hdmi_i2c_responder #(.DEV_ADDR(7'h39), .FILT_LEN(3)) dut (
    .iCLK(clk), .iRST_N(rst_n), .I2C_SCLK(scl), .I2C_SDAT(sda_bus),
    .oSUBADDR(subaddr), .iRD_DATA(rd_data), .oWR_STB(wr_stb),
    .oWR_ADDR(wr_addr), .oWR_DATA(wr_data), .oBUSY(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic glitch, output logic seen);
    wait_cyc(Q);
    tb_sda_low = ~b;
    if (glitch) begin
      wait_cyc(Q / 2);
      scl = 1'b1;
      wait_cyc(1);
      scl = 1'b0;
      wait_cyc(Q - Q / 2 - 1);
    end else begin
      wait_cyc(Q);
    end
    scl = 1'b1;
    wait_cyc(Q);
    seen = sda_bus;
    wait_cyc(Q);
    scl = 1'b0;
  endtask

  task automatic i2c_start();
    wait_cyc(Q);
    tb_sda_low = 1'b0;
    wait_cyc(Q);
    scl = 1'b1;
    wait_cyc(Q);
    tb_sda_low = 1'b1;
    wait_cyc(Q);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_cyc(Q);
    tb_sda_low = 1'b1;
    wait_cyc(Q);
    scl = 1'b1;
    wait_cyc(Q);
    tb_sda_low = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    logic s;
    for (int i = 0; i < 8; i++) send_bit(d[7-i], (i == glitch_bit), s);
    send_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ctrl_ack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, 1'b0, s);
      d = {d[6:0], s};
    end
    send_bit(~ctrl_ack, 1'b0, s);
  endtask

  // Monitor: counts responder pull-downs and scores every write strobe.
  initial forever begin
    @(negedge clk);
    if (rst_n && !tb_sda_low && sda_bus === 1'b0) resp_low_cnt++;
    if (wr_stb) begin
      if (exp_wr_q.size() == 0) begin
        check_val("wr_unexpected", 32'(exp_wr_q.size()), 32'd1);
      end else begin
        mon_e = exp_wr_q.pop_front();
        check_val("wr_addr", {24'h0, wr_addr}, {24'h0, mon_e[15:8]});
        check_val("wr_data", {24'h0, wr_data}, {24'h0, mon_e[7:0]});
      end
    end
  end

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] d;
    int         low0;

    rst_n = 1'b0;
    scl = 1'b1;
    tb_sda_low = 1'b0;
    wait_cyc(5);
    check_val("rst_subaddr", {24'h0, subaddr}, 32'h0);
    check_val("rst_busy", {31'h0, busy}, 32'h0);
    check_val("rst_stb", {31'h0, wr_stb}, 32'h0);
    check_val("rst_wr_addr", {24'h0, wr_addr}, 32'h0);
    check_val("rst_wr_data", {24'h0, wr_data}, 32'h0);
    check_val("rst_sda", {31'h0, sda_bus}, 32'h1);
    rst_n = 1'b1;
    wait_cyc(10);

    // Basic write: addr 0x98 <= 0x03
    exp_wr_q.push_back(16'h9803);
    i2c_start();
    check_val("a_busy_set", {31'h0, busy}, 32'h1);
    send_byte(8'h72, 8, ack); check_val("a_ack_dev", {31'h0, ack}, 32'h1);
    send_byte(8'h98, 8, ack); check_val("a_ack_sub", {31'h0, ack}, 32'h1);
    send_byte(8'h03, 8, ack); check_val("a_ack_wr", {31'h0, ack}, 32'h1);
    i2c_stop();
    wait_cyc(Q);
    check_val("a_subaddr", {24'h0, subaddr}, 32'h99);
    check_val("a_busy_clr", {31'h0, busy}, 32'h0);

    // Wrong address: no ACK, no strobe, busy only
    low0 = resp_low_cnt;
    i2c_start();
    send_byte(8'h74, 8, ack); check_val("b_nack_dev", {31'h0, ack}, 32'h0);
    send_byte(8'h98, 8, ack); check_val("b_nack_sub", {31'h0, ack}, 32'h0);
    check_val("b_busy_set", {31'h0, busy}, 32'h1);
    i2c_stop();
    wait_cyc(Q);
    check_val("b_busy_clr", {31'h0, busy}, 32'h0);
    check_val("b_no_drive", 32'(resp_low_cnt), 32'(low0));
    check_val("b_subaddr", {24'h0, subaddr}, 32'h99);

    // Pointer wrap across 0xFF
    exp_wr_q.push_back(16'hFFAA);
    exp_wr_q.push_back(16'h00BB);
    i2c_start();
    send_byte(8'h72, 8, ack);
    send_byte(8'hFF, 8, ack);
    send_byte(8'hAA, 8, ack); check_val("c_ack_aa", {31'h0, ack}, 32'h1);
    send_byte(8'hBB, 8, ack); check_val("c_ack_bb", {31'h0, ack}, 32'h1);
    i2c_stop();
    wait_cyc(Q);
    check_val("c_subaddr", {24'h0, subaddr}, 32'h01);

    // Pointer set, repeated start, two reads (ACK then NACK)
    i2c_start();
    send_byte(8'h72, 8, ack);
    send_byte(8'h41, 8, ack);
    i2c_start();
    send_byte(8'h73, 8, ack); check_val("d_ack_rd", {31'h0, ack}, 32'h1);
    exp_rd_q.push_back(8'h10);
    read_byte(1'b1, d);
    check_val("d_rd0", {24'h0, d}, {24'h0, exp_rd_q.pop_front()});
    exp_rd_q.push_back(8'h20);
    read_byte(1'b0, d);
    check_val("d_rd1", {24'h0, d}, {24'h0, exp_rd_q.pop_front()});
    low0 = resp_low_cnt;
    wait_cyc(2 * Q);
    check_val("d_nack_release", 32'(resp_low_cnt), 32'(low0));
    check_val("d_busy_hold", {31'h0, busy}, 32'h1);
    i2c_stop();
    wait_cyc(Q);
    check_val("d_subaddr", {24'h0, subaddr}, 32'h42);

    // Short SCL glitch during bit 4 of the data byte
    exp_wr_q.push_back(16'h105A);
    i2c_start();
    send_byte(8'h72, 8, ack);
    send_byte(8'h10, 8, ack);
    send_byte(8'h5A, 3, ack); check_val("e_ack_glitch", {31'h0, ack}, 32'h1);
    i2c_stop();
    wait_cyc(Q);
    check_val("e_subaddr", {24'h0, subaddr}, 32'h11);

    // Reset in the middle of a data byte, then a clean write
    i2c_start();
    send_byte(8'h72, 8, ack);
    send_byte(8'h20, 8, ack);
    send_bit(1'b1, 1'b0, s);
    send_bit(1'b1, 1'b0, s);
    send_bit(1'b0, 1'b0, s);
    tb_sda_low = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("f_sda_rel", {31'h0, sda_bus}, 32'h1);
    check_val("f_subaddr", {24'h0, subaddr}, 32'h0);
    check_val("f_busy", {31'h0, busy}, 32'h0);
    wait_cyc(Q);
    scl = 1'b1;
    wait_cyc(Q);
    rst_n = 1'b1;
    wait_cyc(10);
    exp_wr_q.push_back(16'h3077);
    i2c_start();
    send_byte(8'h72, 8, ack);
    send_byte(8'h30, 8, ack);
    send_byte(8'h77, 8, ack); check_val("f_ack_wr", {31'h0, ack}, 32'h1);
    i2c_stop();
    wait_cyc(Q);
    check_val("f_subaddr_after", {24'h0, subaddr}, 32'h31);

    check_val("wr_pending", 32'(exp_wr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hdmi_i2c_responder.md
HDMI_I2C_RESPONDER -- requirements
Module: hdmi_i2c_responder

Interface
REQ-001 Parameter DEV_ADDR, default 7'h39, 7-bit I2C target address (8-bit write 0x72, read 0x73).
REQ-002 Parameter FILT_LEN, default 3, number of consecutive equal synchronized samples required before SCL/SDA level is accepted.
REQ-003 iCLK  input  1  system clock, 50 MHz; all state on rising edge.
REQ-004 iRST_N  input  1  reset; asynchronous, active-low.
REQ-005 I2C_SCLK  input  1  I2C clock from controller.
REQ-006 I2C_SDAT  inout  1  I2C data, open-drain: block drives 0 or Z, never 1.
REQ-007 oSUBADDR  output  8  current register sub-address pointer.
REQ-008 iRD_DATA  input  8  register content at oSUBADDR, combinational from user side.
REQ-009 oWR_STB  output  1  one-cycle write strobe.
REQ-010 oWR_ADDR  output  8  sub-address of write, valid with oWR_STB.
REQ-011 oWR_DATA  output  8  data of write, valid with oWR_STB.
REQ-012 oBUSY  output  1  high between accepted START and STOP.

Function
REQ-013 SCL and SDA each pass a 2-flop synchronizer then a FILT_LEN-sample glitch filter; edges detected on filtered levels.
REQ-014 START = filtered SDA 1->0 while SCL high; STOP = SDA 0->1 while SCL high; both recognized in every state and take priority over bit activity.
REQ-015 Data bits sampled on filtered SCL rising edge, MSB first; SDA output changes only on filtered SCL falling edge.
REQ-016 States: IDLE, DEVADDR, ACK_DEV, SUBADDR, ACK_SUB, WDATA, ACK_WR, RDATA, RACK.
REQ-017 IDLE -> DEVADDR on START; any state -> IDLE on STOP; START in any non-IDLE state (repeated start) -> DEVADDR, oSUBADDR retained.
REQ-018 DEVADDR: after 8 bits, if bits[7:1]==DEV_ADDR -> ACK_DEV, else -> IDLE with SDA released for remainder of transaction.
REQ-019 ACK: SDA driven low from SCL falling edge after bit 8 until SCL falling edge after bit 9.
REQ-020 ACK_DEV exit: R/W=0 -> SUBADDR; R/W=1 -> RDATA, shift register loaded with iRD_DATA at that falling edge.
REQ-021 SUBADDR: 8 bits loaded into oSUBADDR at bit-8 sample, ACK, -> WDATA.
REQ-022 WDATA: at bit-8 sample, oWR_STB pulses 1 cycle next iCLK with oWR_ADDR=oSUBADDR, oWR_DATA=byte; ACK; oSUBADDR increments at ACK end; -> WDATA.
REQ-023 RDATA: drive SDA low for 0 bits, Z for 1 bits; after 8th bit release SDA -> RACK.
REQ-024 RACK: sample bit 9; 0 (ACK) -> oSUBADDR+1, reload iRD_DATA, -> RDATA; 1 (NACK) -> IDLE-wait, SDA released until STOP/START.
REQ-025 oSUBADDR increment wraps 8'hFF -> 8'h00.
REQ-026 oBUSY set on START recognition, cleared on STOP, independent of address match.
REQ-027 STOP/START mid-byte discards partial byte; no oWR_STB for incomplete byte.

Reset
REQ-028 While iRST_N=0: state IDLE, I2C_SDAT=Z, oSUBADDR=0, oWR_STB=0, oWR_ADDR=0, oWR_DATA=0, oBUSY=0, synchronizers/filters = 1.
REQ-029 After deassertion, block ignores bus until first START seen with filtered SCL high.

Verification
REQ-030 START, 0x72, 0x98, 0x03, STOP -> three ACKs; one oWR_STB with oWR_ADDR=0x98, oWR_DATA=0x03; oSUBADDR=0x99 after.
REQ-031 START, 0x74, 0x98, STOP -> no ACK (SDA never low from responder), no oWR_STB, oBUSY pulse only.
REQ-032 START, 0x72, 0xFF, 0xAA, 0xBB, STOP -> strobes (0xFF,0xAA),(0x00,0xBB); oSUBADDR=0x01.
REQ-033 START, 0x72, 0x41, Sr, 0x73, read with iRD_DATA=0x10 then 0x20 at 0x42, controller ACK then NACK, STOP -> bytes 0x10, 0x20 on bus; SDA released after NACK.
REQ-034 iRST_N low mid-WDATA byte 3 bits in -> SDA Z immediately, no strobe; next full write transaction after release completes normally.
REQ-035 1-cycle SCL glitch (< FILT_LEN) during bit 4 -> no extra bit counted; byte received correctly.
